// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: one-outstanding imem fetcher feeding a DEPTH-entry prefetch FIFO
// of {pc, word}, with branch redirect that flushes the FIFO and drops any in-flight response.
//
// state   | meaning
// FETCH   | may issue a request when the FIFO has room
// WAIT    | request accepted, waiting for its rvalid; pushes the word on arrival
// DROP    | request in flight belongs to a flushed path; its rvalid is discarded
module fetch_prefetch_unit #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic                         imem_req,
   output logic [ADDR_W-1:0]            imem_addr,
   input  logic                         imem_ready,
   input  logic                         imem_rvalid,
   input  logic [DATA_W-1:0]            imem_rdata,
   input  logic                         stall,
   input  logic                         branch_taken,
   input  logic [ADDR_W-1:0]            branch_target,
   output logic                         inst_valid,
   output logic [DATA_W-1:0]            INST,
   output logic [ADDR_W-1:0]            PCOUT,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_FETCH,
      S_WAIT,
      S_DROP
   } state_t;

   state_t             state;
   logic [ADDR_W-1:0]  fetch_pc;
   logic [ADDR_W-1:0]  req_pc;
   logic [DATA_W-1:0]  data_mem [DEPTH];
   logic [ADDR_W-1:0]  pc_mem   [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               accept;
   logic               push;
   logic               pop;

   // A redirect suppresses request, push and pop in the same cycle.
   assign imem_req   = !rst && (state == S_FETCH) && (count < DEPTH_C) && !branch_taken;
   assign accept     = imem_req && imem_ready;
   assign push       = (state == S_WAIT) && imem_rvalid && !branch_taken;
   assign pop        = (count != '0) && !stall && !branch_taken;

   assign imem_addr  = fetch_pc;
   assign fifo_count = count;
   assign inst_valid = (count != '0);
   assign INST       = inst_valid ? data_mem[rd_ptr] : '0;
   assign PCOUT      = inst_valid ? pc_mem[rd_ptr]   : '0;

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         data_mem[wr_ptr] <= imem_rdata;
         pc_mem[wr_ptr]   <= req_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else if (branch_taken) begin
         fetch_pc <= branch_target;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         // A stale response arriving with the redirect retires the only outstanding request.
         case (state)
            S_WAIT:  state <= imem_rvalid ? S_FETCH : S_DROP;
            S_DROP:  state <= imem_rvalid ? S_FETCH : S_DROP;
            default: state <= S_FETCH;
         endcase
      end else begin
         case (state)
            S_FETCH: begin
               if (accept) begin
                  req_pc   <= fetch_pc;
                  fetch_pc <= fetch_pc + ADDR_W'(1);
                  state    <= S_WAIT;
               end
            end
            S_WAIT:  if (imem_rvalid) state <= S_FETCH;
            S_DROP:  if (imem_rvalid) state <= S_FETCH;
            default: state <= S_FETCH;
         endcase
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (!push && pop)
            count <= count - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a behavioural imem responder of configurable latency.
module tb_fetch_prefetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready = 1'b1;
   logic        imem_rvalid = 1'b0;
   logic [15:0] imem_rdata = '0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_target = '0;
   logic        inst_valid;
   logic [15:0] INST;
   logic [15:0] PCOUT;
   logic [2:0]  fifo_count;

   int checks = 0;
   int errors = 0;
   int lat = 1;
   int pend_cnt = 0;
   logic [15:0] pend_addr = '0;

   fetch_prefetch_unit #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .inst_valid(inst_valid), .INST(INST), .PCOUT(PCOUT), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] word_of(input logic [15:0] a);
      return a ^ 16'hC3C3;
   endfunction

   // Memory model: decides at the falling edge whether the next rising edge accepts,
   // and raises rvalid for the edge that is lat cycles after the accepting edge.
   always @(negedge clk) begin
      imem_rvalid = 1'b0;
      if (pend_cnt == 1) begin
         imem_rvalid = 1'b1;
         imem_rdata  = word_of(pend_addr);
         pend_cnt    = 0;
      end else if (pend_cnt > 1) begin
         pend_cnt = pend_cnt - 1;
      end
      if (imem_req && imem_ready) begin
         pend_cnt  = lat;
         pend_addr = imem_addr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int l, input logic s);
      lat = l;
      stall = s;
      branch_taken = 1'b0;
      rst = 1'b1;
      repeat (4) tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; lat = 1; stall = 1'b0;
      repeat (2) tick();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
      checks++; if (INST !== 16'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0000", INST); end
      checks++; if (PCOUT !== 16'h0) begin errors++; $display("FAIL reset_pcout: got %h expected 0000", PCOUT); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
      checks++; if (imem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0000", imem_addr); end
      rst = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL release_req: got %b expected 1", imem_req); end
   endtask

   task automatic test_stream();
      do_reset(1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL stream_gap%0d: got valid=%b req=%b expected 0 0", k, inst_valid, imem_req); end
         tick();
         checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stream_valid%0d: got %b expected 1", k, inst_valid); end
         checks++; if (PCOUT !== 16'(k)) begin errors++; $display("FAIL stream_pc%0d: got %h expected %h", k, PCOUT, 16'(k)); end
         checks++; if (INST !== word_of(16'(k))) begin errors++; $display("FAIL stream_inst%0d: got %h expected %h", k, INST, word_of(16'(k))); end
         checks++; if (imem_req !== 1'b1 || imem_addr !== 16'(k + 1)) begin errors++; $display("FAIL stream_addr%0d: got req=%b addr=%h expected 1 %h", k, imem_req, imem_addr, 16'(k + 1)); end
      end
   endtask

   task automatic test_stall();
      logic [2:0]  ec;
      logic [15:0] exp_pc;
      do_reset(1, 1'b1);
      for (int i = 1; i <= 12; i++) begin
         tick();
         ec = (i / 2 > 4) ? 3'd4 : 3'(i / 2);
         checks++; if (fifo_count !== ec) begin errors++; $display("FAIL stall_count%0d: got %0d expected %0d", i, fifo_count, ec); end
         if (i >= 2) begin
            checks++; if (PCOUT !== 16'h0 || INST !== word_of(16'h0)) begin errors++; $display("FAIL stall_head%0d: got pc=%h inst=%h expected 0000 %h", i, PCOUT, INST, word_of(16'h0)); end
         end
         if (i >= 8) begin
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_full_req%0d: got %b expected 0", i, imem_req); end
         end
      end
      stall = 1'b0;
      #1;
      exp_pc = 16'h0;
      for (int n = 0; n < 30 && exp_pc < 16'd8; n++) begin
         if (inst_valid) begin
            checks++; if (PCOUT !== exp_pc || INST !== word_of(exp_pc)) begin errors++; $display("FAIL drain_pc: got pc=%h inst=%h expected %h %h", PCOUT, INST, exp_pc, word_of(exp_pc)); end
            exp_pc = exp_pc + 16'd1;
         end
         tick();
      end
      checks++; if (exp_pc !== 16'd8) begin errors++; $display("FAIL drain_timeout: got %0d words expected 8", exp_pc); end
   endtask

   task automatic test_branch_fetch();
      do_reset(1, 1'b0);
      branch_taken = 1'b1; branch_target = 16'h0200;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL brf_gate: got req=%b expected 0", imem_req); end
      tick();
      branch_taken = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0200) begin errors++; $display("FAIL brf_addr: got req=%b addr=%h expected 1 0200", imem_req, imem_addr); end
      repeat (2) tick();
      checks++; if (inst_valid !== 1'b1 || PCOUT !== 16'h0200) begin errors++; $display("FAIL brf_first: got valid=%b pc=%h expected 1 0200", inst_valid, PCOUT); end
   endtask

   task automatic test_branch_wait();
      do_reset(3, 1'b1);
      repeat (4) tick();
      checks++; if (fifo_count !== 3'd1 || imem_addr !== 16'h0001) begin errors++; $display("FAIL brw_pre: got count=%0d addr=%h expected 1 0001", fifo_count, imem_addr); end
      tick();
      branch_taken = 1'b1; branch_target = 16'h0040;
      tick();
      branch_taken = 1'b0;
      checks++; if (fifo_count !== 3'd0 || inst_valid !== 1'b0) begin errors++; $display("FAIL brw_flush: got count=%0d valid=%b expected 0 0", fifo_count, inst_valid); end
      tick();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL brw_drop_req: got %b expected 0", imem_req); end
      tick();
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL brw_stale: got count=%0d expected 0", fifo_count); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin errors++; $display("FAIL brw_addr: got req=%b addr=%h expected 1 0040", imem_req, imem_addr); end
      repeat (4) tick();
      checks++; if (inst_valid !== 1'b1 || PCOUT !== 16'h0040 || INST !== word_of(16'h0040)) begin errors++; $display("FAIL brw_first: got valid=%b pc=%h inst=%h expected 1 0040 %h", inst_valid, PCOUT, INST, word_of(16'h0040)); end
   endtask

   task automatic test_branch_rvalid();
      do_reset(1, 1'b1);
      repeat (3) tick();
      checks++; if (fifo_count !== 3'd1 || imem_req !== 1'b0) begin errors++; $display("FAIL brv_pre: got count=%0d req=%b expected 1 0", fifo_count, imem_req); end
      branch_taken = 1'b1; branch_target = 16'h0123; stall = 1'b0;
      tick();
      branch_taken = 1'b0;
      #1;
      checks++; if (fifo_count !== 3'd0 || inst_valid !== 1'b0) begin errors++; $display("FAIL brv_flush: got count=%0d valid=%b expected 0 0", fifo_count, inst_valid); end
      checks++; if (INST !== 16'h0 || PCOUT !== 16'h0) begin errors++; $display("FAIL brv_zero: got inst=%h pc=%h expected 0000 0000", INST, PCOUT); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0123) begin errors++; $display("FAIL brv_addr: got req=%b addr=%h expected 1 0123", imem_req, imem_addr); end
      repeat (2) tick();
      checks++; if (inst_valid !== 1'b1 || PCOUT !== 16'h0123 || INST !== word_of(16'h0123)) begin errors++; $display("FAIL brv_first: got valid=%b pc=%h inst=%h expected 1 0123 %h", inst_valid, PCOUT, INST, word_of(16'h0123)); end
   endtask

   task automatic test_wrap();
      do_reset(1, 1'b1);
      branch_taken = 1'b1; branch_target = 16'hFFFF;
      tick();
      branch_taken = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre: got req=%b addr=%h expected 1 ffff", imem_req, imem_addr); end
      repeat (2) tick();
      checks++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_addr: got req=%b addr=%h expected 1 0000", imem_req, imem_addr); end
      checks++; if (PCOUT !== 16'hFFFF || INST !== word_of(16'hFFFF)) begin errors++; $display("FAIL wrap_pc: got pc=%h inst=%h expected ffff %h", PCOUT, INST, word_of(16'hFFFF)); end
      repeat (2) tick();
      checks++; if (fifo_count !== 3'd2 || PCOUT !== 16'hFFFF) begin errors++; $display("FAIL wrap_hold: got count=%0d pc=%h expected 2 ffff", fifo_count, PCOUT); end
      stall = 1'b0;
      tick();
      checks++; if (fifo_count !== 3'd1 || PCOUT !== 16'h0000 || INST !== word_of(16'h0000)) begin errors++; $display("FAIL wrap_next: got count=%0d pc=%h inst=%h expected 1 0000 %h", fifo_count, PCOUT, INST, word_of(16'h0000)); end
   endtask

   task automatic test_reset_mid();
      do_reset(2, 1'b1);
      repeat (10) tick();
      checks++; if (fifo_count !== 3'd3 || imem_req !== 1'b0) begin errors++; $display("FAIL rmid_pre: got count=%0d req=%b expected 3 0", fifo_count, imem_req); end
      rst = 1'b1;
      tick();
      checks++; if (inst_valid !== 1'b0 || INST !== 16'h0 || PCOUT !== 16'h0) begin errors++; $display("FAIL rmid_out: got valid=%b inst=%h pc=%h expected 0 0000 0000", inst_valid, INST, PCOUT); end
      checks++; if (fifo_count !== 3'd0 || imem_addr !== 16'h0000) begin errors++; $display("FAIL rmid_state: got count=%0d addr=%h expected 0 0000", fifo_count, imem_addr); end
      rst = 1'b0;
      tick();
      checks++; if (fifo_count !== 3'd0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rmid_late: got count=%0d valid=%b expected 0 0", fifo_count, inst_valid); end
      repeat (2) tick();
      checks++; if (fifo_count !== 3'd1 || PCOUT !== 16'h0000 || INST !== word_of(16'h0000)) begin errors++; $display("FAIL rmid_refetch: got count=%0d pc=%h inst=%h expected 1 0000 %h", fifo_count, PCOUT, INST, word_of(16'h0000)); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_branch_fetch();
      test_branch_wait();
      test_branch_rvalid();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
